// File: rtl/afifo_mon_pkg.sv
// Shared types for the FIFO write-side protocol monitor.
package afifo_mon_pkg;

  typedef enum logic [1:0] {
    ERR_NONE           = 2'd0,
    ERR_WR_WHEN_FULL   = 2'd1,
    ERR_PREMATURE_FULL = 2'd2,
    ERR_FULL_TIMEOUT   = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_CAPTURED = 2'd2
  } mon_state_e;

  // Per-channel error vector: bit k set means error code k+1 fired this cycle.
  typedef logic [2:0] err_vec_t;

  // Highest-priority code present in a channel's error vector (3 > 2 > 1).
  function automatic err_code_e vec_to_code(input err_vec_t v);
    if (v[2])      return ERR_FULL_TIMEOUT;
    else if (v[1]) return ERR_PREMATURE_FULL;
    else if (v[0]) return ERR_WR_WHEN_FULL;
    else           return ERR_NONE;
  endfunction

endpackage

// File: rtl/afifo_wr_monitor_if.sv
// FIFO write-port bundle observed by the monitor (one bit per channel).
interface afifo_wr_monitor_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] winc;
  logic [NUM_CH-1:0] wfull;

  // FIFO side drives the write request and full flag.
  modport master (output winc, output wfull);
  // Monitor side only observes.
  modport slave  (input winc, input wfull);
endinterface

// File: rtl/afifo_wr_mon_chan.sv
// Per-channel write tracking: accepted-write count, full-run length and
// the raw (unmasked) error vector for one FIFO channel.
module afifo_wr_mon_chan
  import afifo_mon_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int FULL_TIMEOUT = 64
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     winc,
  input  logic     wfull,
  output err_vec_t err_vec
);
  localparam int WC_W = $clog2(DEPTH + 1);
  localparam int FC_W = $clog2(FULL_TIMEOUT + 1);

  logic [WC_W-1:0] wr_cnt_reg;
  logic [FC_W-1:0] full_cnt_reg;
  logic            wfull_q_reg;

  // Accepted writes saturate at DEPTH; only reset clears them so a FIFO
  // that has been filled once stays "legally fillable".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_reg <= '0;
    end else if (winc && !wfull && (wr_cnt_reg != WC_W'(DEPTH))) begin
      wr_cnt_reg <= wr_cnt_reg + 1'b1;
    end
  end

  // Consecutive-full counter holds at the timeout so it fires once per episode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_cnt_reg <= '0;
      wfull_q_reg  <= 1'b0;
    end else begin
      wfull_q_reg <= wfull;
      if (!wfull) begin
        full_cnt_reg <= '0;
      end else if (full_cnt_reg != FC_W'(FULL_TIMEOUT)) begin
        full_cnt_reg <= full_cnt_reg + 1'b1;
      end
    end
  end

  // Raw error conditions; the top decides whether they are being checked.
  always_comb begin
    err_vec    = '0;
    err_vec[0] = winc && wfull;
    err_vec[1] = wfull && !wfull_q_reg && (wr_cnt_reg < WC_W'(DEPTH));
    err_vec[2] = wfull && (full_cnt_reg == FC_W'(FULL_TIMEOUT - 1));
  end

endmodule

// File: rtl/afifo_wr_monitor.sv
// Write-domain FIFO protocol monitor: per-channel checks, priority report,
// sticky status, saturating error count and first-error capture.
module afifo_wr_monitor
  import afifo_mon_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DEPTH        = 16,
  parameter int FULL_TIMEOUT = 64,
  parameter int CNT_W        = 16,
  parameter int TS_W         = 32,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  enable,
  input  logic                  clr,
  afifo_wr_monitor_if.slave     fifo,
  output logic                  err_valid,
  output logic [1:0]            err_code,
  output logic [CH_W-1:0]       err_chan,
  output logic [3*NUM_CH-1:0]   err_sticky,
  output logic [CNT_W-1:0]      err_count,
  output logic [1:0]            first_code,
  output logic [CH_W-1:0]       first_chan,
  output logic [TS_W-1:0]       first_ts,
  output logic [1:0]            mon_state
);
  localparam int SW = CNT_W + 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mon_state_e          state_reg, state_next;
  logic [TS_W-1:0]     ts_reg;
  logic [3*NUM_CH-1:0] raw_err;
  logic [3*NUM_CH-1:0] masked_err;
  logic [7:0]          pop;
  logic                win_any;
  err_code_e           win_code;
  logic [CH_W-1:0]     win_chan;
  logic [SW-1:0]       cnt_sum;
  logic [CNT_W-1:0]    cnt_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      afifo_wr_mon_chan #(
        .DEPTH       (DEPTH),
        .FULL_TIMEOUT(FULL_TIMEOUT)
      ) u_chan (
        .clk    (wclk),
        .rst_n  (wrst_n),
        .winc   (fifo.winc[gi]),
        .wfull  (fifo.wfull[gi]),
        .err_vec(raw_err[3*gi +: 3])
      );
    end
  endgenerate

  // Mask, winner select (lowest channel wins), popcount and saturating sum.
  always_comb begin
    masked_err = (state_reg != ST_IDLE) ? raw_err : '0;
    pop        = '0;
    win_any    = 1'b0;
    win_code   = ERR_NONE;
    win_chan   = '0;
    for (int k = 0; k < 3*NUM_CH; k++) begin
      pop = pop + 8'(masked_err[k]);
    end
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (|masked_err[3*i +: 3]) begin
        win_any  = 1'b1;
        win_code = vec_to_code(masked_err[3*i +: 3]);
        win_chan = CH_W'(i);
      end
    end
    cnt_sum  = SW'(err_count) + SW'(pop);
    cnt_next = (cnt_sum[SW-1:CNT_W] != '0) ? CNT_MAX : cnt_sum[CNT_W-1:0];
  end

  // Next-state: disable forces IDLE, clr re-arms, first error captures.
  always_comb begin
    state_next = state_reg;
    if (!enable) begin
      state_next = ST_IDLE;
    end else if (clr) begin
      state_next = ST_ARMED;
    end else begin
      case (state_reg)
        ST_IDLE:     state_next = ST_ARMED;
        ST_ARMED:    if (win_any) state_next = ST_CAPTURED;
        ST_CAPTURED: state_next = ST_CAPTURED;
        default:     state_next = ST_IDLE;
      endcase
    end
  end

  // State register and free-running timestamp.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_reg <= ST_IDLE;
      ts_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ts_reg    <= ts_reg + 1'b1;
    end
  end

  // Error report, sticky/count status and first-error capture; clr wins.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      err_valid  <= 1'b0;
      err_code   <= '0;
      err_chan   <= '0;
      err_sticky <= '0;
      err_count  <= '0;
      first_code <= '0;
      first_chan <= '0;
      first_ts   <= '0;
    end else if (clr) begin
      err_valid  <= 1'b0;
      err_sticky <= '0;
      err_count  <= '0;
      first_code <= '0;
      first_chan <= '0;
      first_ts   <= '0;
    end else begin
      err_valid <= win_any;
      if (win_any) begin
        err_code   <= win_code;
        err_chan   <= win_chan;
        err_sticky <= err_sticky | masked_err;
        err_count  <= cnt_next;
        if (state_reg == ST_ARMED) begin
          first_code <= win_code;
          first_chan <= win_chan;
          first_ts   <= ts_reg;
        end
      end
    end
  end

  assign mon_state = state_reg;

endmodule

// File: tb/tb_afifo_wr_monitor.sv
// Self-checking bench for afifo_wr_monitor with an integer-level reference model.
module tb_afifo_wr_monitor;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 16;
  localparam int FT     = 64;
  localparam int CNT_W  = 16;
  localparam int TS_W   = 32;
  localparam int CH_W   = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic                wclk = 1'b0;
  logic                wrst_n = 1'b0;
  logic                enable = 1'b0;
  logic                clr = 1'b0;
  logic                err_valid;
  logic [1:0]          err_code;
  logic [CH_W-1:0]     err_chan;
  logic [3*NUM_CH-1:0] err_sticky;
  logic [CNT_W-1:0]    err_count;
  logic [1:0]          first_code;
  logic [CH_W-1:0]     first_chan;
  logic [TS_W-1:0]     first_ts;
  logic [1:0]          mon_state;

  afifo_wr_monitor_if #(.NUM_CH(NUM_CH)) fifo_if ();

  afifo_wr_monitor #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .FULL_TIMEOUT(FT), .CNT_W(CNT_W), .TS_W(TS_W)
  ) dut (
    .wclk(wclk), .wrst_n(wrst_n), .enable(enable), .clr(clr), .fifo(fifo_if.slave),
    .err_valid(err_valid), .err_code(err_code), .err_chan(err_chan),
    .err_sticky(err_sticky), .err_count(err_count), .first_code(first_code),
    .first_chan(first_chan), .first_ts(first_ts), .mon_state(mon_state)
  );

  always #5 wclk = ~wclk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int                  m_state;
  bit                  m_valid;
  int                  m_code, m_chan, m_fcode, m_fchan, m_count;
  logic [3*NUM_CH-1:0] m_sticky;
  logic [TS_W-1:0]     m_ts, m_fts;
  int                  m_writes [NUM_CH];
  int                  m_run    [NUM_CH];
  bit                  m_prev   [NUM_CH];

  task automatic model_reset();
    m_state = 0; m_valid = 0; m_code = 0; m_chan = 0; m_fcode = 0; m_fchan = 0;
    m_count = 0; m_sticky = '0; m_ts = '0; m_fts = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_writes[i] = 0; m_run[i] = 0; m_prev[i] = 0;
    end
  endtask

  // Advance the model by one cycle from the current inputs, then clock the DUT.
  task automatic tick();
    bit chk, e1, e2, e3, found;
    int n, wcode, wchan;
    logic [3*NUM_CH-1:0] new_bits;
    chk = (m_state != 0);
    n = 0; found = 0; wcode = 0; wchan = 0; new_bits = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      e1 = fifo_if.winc[i] && fifo_if.wfull[i];
      e2 = fifo_if.wfull[i] && !m_prev[i] && (m_writes[i] < DEPTH);
      e3 = fifo_if.wfull[i] && (m_run[i] + 1 == FT);
      if (!chk) begin e1 = 0; e2 = 0; e3 = 0; end
      n = n + int'(e1) + int'(e2) + int'(e3);
      if (e1) new_bits[3*i]   = 1'b1;
      if (e2) new_bits[3*i+1] = 1'b1;
      if (e3) new_bits[3*i+2] = 1'b1;
      if (!found && (e1 || e2 || e3)) begin
        found = 1; wchan = i;
        wcode = e3 ? 3 : (e2 ? 2 : 1);
      end
      if (fifo_if.winc[i] && !fifo_if.wfull[i]) m_writes[i]++;
      m_run[i]  = fifo_if.wfull[i] ? m_run[i] + 1 : 0;
      m_prev[i] = fifo_if.wfull[i];
    end
    if (clr) begin
      m_valid = 0; m_sticky = '0; m_count = 0; m_fcode = 0; m_fchan = 0; m_fts = '0;
      m_state = enable ? 1 : 0;
    end else begin
      m_valid = found;
      if (found) begin
        m_code = wcode; m_chan = wchan;
        m_sticky = m_sticky | new_bits;
        m_count = (m_count + n > CMAX) ? CMAX : m_count + n;
        if (m_state == 1) begin m_fcode = wcode; m_fchan = wchan; m_fts = m_ts; end
      end
      if (!enable)            m_state = 0;
      else if (m_state == 0)  m_state = 1;
      else if (m_state == 1 && found) m_state = 2;
    end
    m_ts = m_ts + 1'b1;
    @(posedge wclk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge wclk);
    wrst_n = 1'b0;
    enable = 1'b0; clr = 1'b0;
    fifo_if.winc = '0; fifo_if.wfull = '0;
    model_reset();
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [3*NUM_CH+CNT_W+TS_W+2*CH_W+7:0] all_out;
    apply_reset();
    @(negedge wclk);
    wrst_n = 1'b0;
    #1;
    all_out = {err_valid, err_code, err_chan, err_sticky, err_count,
               first_code, first_chan, first_ts, mon_state};
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %0h expected 0", all_out);
    end
    @(negedge wclk);
    wrst_n = 1'b1;
    $display("reset: outputs=%0h", all_out);
  endtask

  task automatic test_legal_full();
    enable = 1'b1;
    tick();
    n_cmp++;
    if (mon_state !== 2'd1) begin n_bad++; $display("FAIL arm_state: got %0d expected 1", mon_state); end
    fifo_if.winc[0] = 1'b1;
    repeat (DEPTH) tick();
    fifo_if.winc[0] = 1'b0; fifo_if.wfull[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (err_valid !== 1'b0) begin n_bad++; $display("FAIL legal_full_valid: got %0b expected 0", err_valid); end
    end
    n_cmp++;
    if (err_count !== '0 || mon_state !== 2'd1) begin
      n_bad++; $display("FAIL legal_full_status: got count=%0d state=%0d expected count=0 state=1", err_count, mon_state);
    end
    fifo_if.wfull[0] = 1'b0;
    tick();
    $display("legal_full: count=%0d state=%0d", err_count, mon_state);
  endtask

  task automatic test_premature();
    logic [TS_W-1:0] t_rise;
    fifo_if.winc[1] = 1'b1;
    repeat (3) tick();
    fifo_if.winc[1] = 1'b0; fifo_if.wfull[1] = 1'b1;
    t_rise = m_ts;
    tick();
    n_cmp++;
    if ({err_valid, err_code, err_chan} !== {1'b1, 2'd2, 2'd1}) begin
      n_bad++; $display("FAIL premature_report: got v=%0b code=%0d chan=%0d expected v=1 code=2 chan=1", err_valid, err_code, err_chan);
    end
    n_cmp++;
    if (first_ts !== t_rise || first_code !== 2'd2 || first_chan !== 2'd1) begin
      n_bad++; $display("FAIL premature_first: got ts=%0d code=%0d chan=%0d expected ts=%0d code=2 chan=1", first_ts, first_code, first_chan, t_rise);
    end
    n_cmp++;
    if (mon_state !== 2'd2 || err_sticky[4] !== 1'b1 || err_count !== 16'd1) begin
      n_bad++; $display("FAIL premature_status: got state=%0d sticky=%0h count=%0d expected state=2 bit4 count=1", mon_state, err_sticky, err_count);
    end
    fifo_if.wfull[1] = 1'b0;
    tick();
    n_cmp++;
    if (err_valid !== 1'b0 || err_code !== 2'd2) begin
      n_bad++; $display("FAIL premature_pulse: got v=%0b code=%0d expected v=0 code=2", err_valid, err_code);
    end
    $display("premature: first_ts=%0d", first_ts);
  endtask

  task automatic test_wr_when_full();
    int exp_cnt;
    logic [TS_W-1:0] f_ts;
    f_ts = m_fts;
    exp_cnt = m_count + 3;
    fifo_if.winc[2] = 1'b1;
    repeat (DEPTH) tick();
    fifo_if.wfull[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({err_valid, err_code, err_chan} !== {1'b1, 2'd1, 2'd2}) begin
        n_bad++; $display("FAIL wwf_pulse%0d: got v=%0b code=%0d chan=%0d expected v=1 code=1 chan=2", i, err_valid, err_code, err_chan);
      end
    end
    fifo_if.winc[2] = 1'b0; fifo_if.wfull[2] = 1'b0;
    tick();
    n_cmp++;
    if (int'(err_count) != exp_cnt || err_sticky[6] !== 1'b1) begin
      n_bad++; $display("FAIL wwf_status: got count=%0d sticky=%0h expected count=%0d bit6", err_count, err_sticky, exp_cnt);
    end
    n_cmp++;
    if (first_ts !== f_ts || first_chan !== 2'd1) begin
      n_bad++; $display("FAIL wwf_first_kept: got ts=%0d chan=%0d expected ts=%0d chan=1", first_ts, first_chan, f_ts);
    end
    $display("wr_when_full: count=%0d", err_count);
  endtask

  task automatic test_timeout();
    int pulses, at, len;
    fifo_if.winc[3] = 1'b1;
    repeat (DEPTH) tick();
    fifo_if.winc[3] = 1'b0;
    for (int ep = 0; ep < 2; ep++) begin
      len = (ep == 0) ? 70 : 66;
      pulses = 0; at = 0;
      fifo_if.wfull[3] = 1'b1;
      for (int i = 1; i <= len; i++) begin
        tick();
        if (err_valid) begin
          pulses++; at = i;
          n_cmp++;
          if (err_code !== 2'd3 || err_chan !== 2'd3) begin
            n_bad++; $display("FAIL timeout_code: got code=%0d chan=%0d expected code=3 chan=3", err_code, err_chan);
          end
        end
      end
      n_cmp++;
      if (pulses != 1 || at != FT) begin
        n_bad++; $display("FAIL timeout_ep%0d: got pulses=%0d at=%0d expected pulses=1 at=%0d", ep, pulses, at, FT);
      end
      fifo_if.wfull[3] = 1'b0;
      tick();
      $display("timeout ep%0d: pulses=%0d at=%0d", ep, pulses, at);
    end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    enable = 1'b1;
    tick();
    fifo_if.winc[3] = 1'b1;
    repeat (DEPTH) tick();
    fifo_if.wfull[3] = 1'b1; fifo_if.wfull[0] = 1'b1;
    tick();
    n_cmp++;
    if ({err_valid, err_code, err_chan} !== {1'b1, 2'd2, 2'd0}) begin
      n_bad++; $display("FAIL same_cycle_winner: got v=%0b code=%0d chan=%0d expected v=1 code=2 chan=0", err_valid, err_code, err_chan);
    end
    n_cmp++;
    if (err_count !== 16'd2 || err_sticky !== 12'h202) begin
      n_bad++; $display("FAIL same_cycle_status: got count=%0d sticky=%0h expected count=2 sticky=202", err_count, err_sticky);
    end
    $display("same_cycle: chan=%0d code=%0d count=%0d", err_chan, err_code, err_count);
  endtask

  task automatic test_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_cmp++;
    if (err_valid !== 1'b0 || err_sticky !== '0 || err_count !== '0) begin
      n_bad++; $display("FAIL clr_status: got v=%0b sticky=%0h count=%0d expected all 0", err_valid, err_sticky, err_count);
    end
    n_cmp++;
    if (first_code !== '0 || first_chan !== '0 || first_ts !== '0 || mon_state !== 2'd1) begin
      n_bad++; $display("FAIL clr_first: got code=%0d chan=%0d ts=%0d state=%0d expected 0 0 0 1", first_code, first_chan, first_ts, mon_state);
    end
    fifo_if.winc = '0; fifo_if.wfull = '0;
    tick();
    $display("clr: state=%0d count=%0d", mon_state, err_count);
  endtask

  task automatic test_random();
    logic [3*NUM_CH+CNT_W+TS_W+2*CH_W+7:0] got, exp;
    for (int c = 0; c < 1500; c++) begin
      fifo_if.winc = NUM_CH'($urandom);
      for (int i = 0; i < NUM_CH; i++)
        if ($urandom_range(0, 9) == 0) fifo_if.wfull[i] = ~fifo_if.wfull[i];
      enable = ($urandom_range(0, 49) != 0);
      clr    = ($urandom_range(0, 99) == 0);
      tick();
      got = {err_valid, err_code, err_chan, err_sticky, err_count,
             first_code, first_chan, first_ts, mon_state};
      exp = {m_valid, 2'(m_code), CH_W'(m_chan), m_sticky, CNT_W'(m_count),
             2'(m_fcode), CH_W'(m_fchan), m_fts, 2'(m_state)};
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL random_cycle%0d: got %0h expected %0h", c, got, exp);
      end
    end
    clr = 1'b0; enable = 1'b1;
    $display("random: count=%0d state=%0d", err_count, mon_state);
  endtask

  task automatic test_async_reset();
    logic [3*NUM_CH+CNT_W+TS_W+2*CH_W+7:0] all_out;
    fifo_if.winc = '1; fifo_if.wfull = '1;
    repeat (3) tick();
    #2;
    wrst_n = 1'b0;
    #1;
    all_out = {err_valid, err_code, err_chan, err_sticky, err_count,
               first_code, first_chan, first_ts, mon_state};
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++; $display("FAIL async_reset: got %0h expected 0", all_out);
    end
    fifo_if.winc = '0; fifo_if.wfull = '0; enable = 1'b0;
    model_reset();
    @(negedge wclk);
    wrst_n = 1'b1;
    $display("async_reset: outputs=%0h", all_out);
  endtask

  initial begin
    fifo_if.winc = '0;
    fifo_if.wfull = '0;
    model_reset();
    test_reset();
    test_legal_full();
    test_premature();
    test_wr_when_full();
    test_timeout();
    test_same_cycle();
    test_clr();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
